reorder_buffer: RTL and testbench
=================================

Name: reorder_buffer

Overview:
- In-order retirement end of the out-of-order backend. Allocates a 5-bit tag per dispatched instruction, consumes CDB result broadcasts, and retires instructions in program order.
- Generates the retire-bus signals that the issue queues consume: RB_Store_Ready and RB_Flush_Valid.
- Sits between dispatch (tag/full handshake) and the architectural register file (retire write port).

Parameters:
DEPTH, 32, number of entries; must equal 2**TAG_W
TAG_W, 5, tag width; tag equals entry index

Ports:
Clk  in  1  clock, rising edge
Rst  in  1  reset, asynchronous, active-low
Dispatch_Valid  in  1  allocate one entry this cycle
Dispatch_Rd_Reg  in  5  architectural destination register
Dispatch_Is_Store  in  1  entry is a store
Dispatch_Is_Branch  in  1  entry is a branch
Dispatch_Pred_Taken  in  1  predicted direction of a branch
ROB_Tag  out  TAG_W  tag that the next allocation receives (tail pointer)
ROB_Full  out  1  no free entry
CDB_Tag  in  TAG_W  broadcast tag
CDB_Data  in  32  broadcast result
CDB_Valid  in  1  broadcast valid
CDB_Branch  in  1  broadcast is a branch resolution
CDB_Branch_Taken  in  1  resolved branch direction
Retire_Valid  out  1  register writeback this cycle
Retire_Rd_Reg  out  5  writeback register
Retire_Data  out  32  writeback data
Retire_Tag  out  TAG_W  tag being freed
RB_Store_Ready  out  1  store at head may commit (one-cycle pulse)
RB_Flush_Valid  out  1  mispredict flush (one-cycle pulse)

Behaviour:
- Reset (Rst=0, asynchronous):
  - head=tail=0, count=0, all entry valid/complete bits cleared.
  - All outputs 0; ROB_Tag=0.
- Storage per entry: valid, complete, is_store, is_branch, pred_taken, actual_taken, rd_reg[4:0], data[31:0].
- ROB_Full = (count==DEPTH), decoded from registered count.
- ROB_Tag = tail, combinational from the register.
- Allocation:
  - Occurs when Dispatch_Valid=1 and ROB_Full=0.
  - Writes the entry at tail with valid=1. complete=Dispatch_Is_Store (stores need no CDB result).
  - tail increments mod DEPTH (31 wraps to 0).
  - Dispatch_Valid while ROB_Full=1 is ignored: no state change.
- CDB write:
  - Occurs when CDB_Valid=1 and entry[CDB_Tag].valid=1 and complete=0.
  - Sets complete=1 and data=CDB_Data. If CDB_Branch=1, also sets actual_taken=CDB_Branch_Taken.
  - Broadcast to an invalid or already-complete entry is ignored.
- Retire:
  - At most one per cycle. Decided at the clock edge from the head entry's registered state; all retire outputs are registered.
  - Latency: a CDB write at edge E lets the head retire at edge E+1, so outputs are high for the cycle after E+1.
  - Head valid and complete, plain (not store, not branch): Retire_Valid=1 with rd_reg, data and head tag; entry freed; head++.
  - Head is a store: RB_Store_Ready=1 for one cycle; Retire_Tag=head; Retire_Valid=0; entry freed; head++.
  - Head is a branch with actual_taken==pred_taken: entry freed, head++, no pulse.
  - Head is a branch with actual_taken!=pred_taken (mispredict): RB_Flush_Valid=1 for one cycle. At that same edge all entries are invalidated and head=tail=count=0.
  - Head not complete: no retire; all pulses 0.
- count update: +1 on accepted allocation, -1 on retire, unchanged when both happen in the same cycle.
- Flush precedence:
  - Flush overrides a same-cycle allocation (dispatch dropped) and a same-cycle CDB write.
  - Dispatch resumes the following cycle with ROB_Tag=0.
- Full and retire in the same cycle:
  - Allocation is still blocked, because ROB_Full comes from registered count.
  - ROB_Full deasserts the next cycle.
- Empty (count=0): no retire; outputs 0.
- Reset mid-operation: asynchronously returns to the reset state; in-flight pulses are dropped.

Test Plan:
1. Reset, then dispatch 3 plain ops (Rd 1,2,3); CDB writes tag 1 (0xB), tag 0 (0xA), tag 2 (0xC) -> retire in order: tag0/R1/0xA, tag1/R2/0xB, tag2/R3/0xC on consecutive cycles; count returns to 0.
2. Dispatch 32 ops -> ROB_Full=1 and 33rd dispatch ignored (ROB_Tag stays 0). Complete tag 0 -> one retire, ROB_Full=0 the next cycle, next allocation gets tag 0 (wrap).
3. Dispatch store (tag 0) then plain (tag 1) -> RB_Store_Ready pulses exactly one cycle with Retire_Tag=0 and Retire_Valid=0; tag 1 retires only after CDB writes it.
4. Dispatch branch with pred_taken=0 (tag 0) plus 2 plain ops; CDB tag 0 with CDB_Branch=1, Taken=1 -> RB_Flush_Valid single pulse, ROB_Tag=0, count=0, no Retire_Valid for tags 1-2. A dispatch in the flush cycle is dropped.
5. Correctly predicted branch (pred=1, actual=1) -> no flush pulse; entry freed; following entry retires normally.
6. CDB_Valid with an unallocated tag (5) and a repeated write to a completed tag -> no state change. Drive Rst=0 asynchronously mid-stream -> all outputs 0 immediately, ROB_Tag=0.

Source files
------------

// File: rtl/reorder_buffer.sv
// Reorder buffer: allocates tags at the tail, completes entries from the CDB and
// retires them in program order from the head, raising store-commit and flush pulses.
module reorder_buffer #(
    parameter int DEPTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Dispatch_Valid,
    input  logic [4:0]       Dispatch_Rd_Reg,
    input  logic             Dispatch_Is_Store,
    input  logic             Dispatch_Is_Branch,
    input  logic             Dispatch_Pred_Taken,
    output logic [TAG_W-1:0] ROB_Tag,
    output logic             ROB_Full,
    input  logic [TAG_W-1:0] CDB_Tag,
    input  logic [31:0]      CDB_Data,
    input  logic             CDB_Valid,
    input  logic             CDB_Branch,
    input  logic             CDB_Branch_Taken,
    output logic             Retire_Valid,
    output logic [4:0]       Retire_Rd_Reg,
    output logic [31:0]      Retire_Data,
    output logic [TAG_W-1:0] Retire_Tag,
    output logic             RB_Store_Ready,
    output logic             RB_Flush_Valid
);

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] complete_q;
    logic [DEPTH-1:0] is_store_q;
    logic [DEPTH-1:0] is_branch_q;
    logic [DEPTH-1:0] pred_q;
    logic [DEPTH-1:0] actual_q;
    logic [4:0]       rd_q   [DEPTH];
    logic [31:0]      data_q [DEPTH];

    logic [TAG_W-1:0] head_q;
    logic [TAG_W-1:0] tail_q;
    logic [TAG_W:0]   count_q;

    logic full;
    logic head_ready;
    logic mispredict;
    logic retire;
    logic alloc;
    logic cdb_wr;

    assign full       = (count_q == (TAG_W+1)'(DEPTH));
    assign head_ready = valid_q[head_q] & complete_q[head_q];
    assign mispredict = head_ready & is_branch_q[head_q] & (actual_q[head_q] != pred_q[head_q]);
    assign retire     = head_ready & ~mispredict;
    assign alloc      = Dispatch_Valid & ~full & ~mispredict;
    assign cdb_wr     = CDB_Valid & valid_q[CDB_Tag] & ~complete_q[CDB_Tag] & ~mispredict;

    assign ROB_Tag  = tail_q;
    assign ROB_Full = full;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            valid_q        <= '0;
            complete_q     <= '0;
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            Retire_Valid   <= 1'b0;
            Retire_Rd_Reg  <= '0;
            Retire_Data    <= '0;
            Retire_Tag     <= '0;
            RB_Store_Ready <= 1'b0;
            RB_Flush_Valid <= 1'b0;
        end else begin
            Retire_Valid   <= 1'b0;
            Retire_Rd_Reg  <= '0;
            Retire_Data    <= '0;
            Retire_Tag     <= '0;
            RB_Store_Ready <= 1'b0;
            RB_Flush_Valid <= 1'b0;
            if (mispredict) begin
                valid_q        <= '0;
                complete_q     <= '0;
                head_q         <= '0;
                tail_q         <= '0;
                count_q        <= '0;
                RB_Flush_Valid <= 1'b1;
            end else begin
                if (retire) begin
                    valid_q[head_q]    <= 1'b0;
                    complete_q[head_q] <= 1'b0;
                    head_q             <= head_q + TAG_W'(1);
                    if (is_store_q[head_q]) begin
                        RB_Store_Ready <= 1'b1;
                        Retire_Tag     <= head_q;
                    end else if (!is_branch_q[head_q]) begin
                        Retire_Valid  <= 1'b1;
                        Retire_Rd_Reg <= rd_q[head_q];
                        Retire_Data   <= data_q[head_q];
                        Retire_Tag    <= head_q;
                    end
                end
                if (cdb_wr) begin
                    complete_q[CDB_Tag] <= 1'b1;
                end
                if (alloc) begin
                    valid_q[tail_q]    <= 1'b1;
                    complete_q[tail_q] <= Dispatch_Is_Store;
                    tail_q             <= tail_q + TAG_W'(1);
                end
                case ({alloc, retire})
                    2'b10:   count_q <= count_q + (TAG_W+1)'(1);
                    2'b01:   count_q <= count_q - (TAG_W+1)'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    // Payload needs no reset: every use is qualified by the valid/complete bits.
    // actual starts equal to the prediction so a branch completed without a
    // resolution flag retires as correctly predicted.
    always_ff @(posedge Clk) begin
        if (alloc) begin
            rd_q[tail_q]        <= Dispatch_Rd_Reg;
            is_store_q[tail_q]  <= Dispatch_Is_Store;
            is_branch_q[tail_q] <= Dispatch_Is_Branch;
            pred_q[tail_q]      <= Dispatch_Pred_Taken;
            actual_q[tail_q]    <= Dispatch_Pred_Taken;
        end
        if (cdb_wr) begin
            data_q[CDB_Tag] <= CDB_Data;
            if (CDB_Branch) begin
                actual_q[CDB_Tag] <= CDB_Branch_Taken;
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: vector table for in-order retire and store
// commit, hand sequences for full/wrap, flush, branch, ignored CDB writes and async reset.
module tb_reorder_buffer;

    logic        Clk;
    logic        Rst;
    logic        Dispatch_Valid;
    logic [4:0]  Dispatch_Rd_Reg;
    logic        Dispatch_Is_Store;
    logic        Dispatch_Is_Branch;
    logic        Dispatch_Pred_Taken;
    logic [4:0]  ROB_Tag;
    logic        ROB_Full;
    logic [4:0]  CDB_Tag;
    logic [31:0] CDB_Data;
    logic        CDB_Valid;
    logic        CDB_Branch;
    logic        CDB_Branch_Taken;
    logic        Retire_Valid;
    logic [4:0]  Retire_Rd_Reg;
    logic [31:0] Retire_Data;
    logic [4:0]  Retire_Tag;
    logic        RB_Store_Ready;
    logic        RB_Flush_Valid;

    reorder_buffer #(.DEPTH(32), .TAG_W(5)) dut (
        .Clk(Clk), .Rst(Rst),
        .Dispatch_Valid(Dispatch_Valid), .Dispatch_Rd_Reg(Dispatch_Rd_Reg),
        .Dispatch_Is_Store(Dispatch_Is_Store), .Dispatch_Is_Branch(Dispatch_Is_Branch),
        .Dispatch_Pred_Taken(Dispatch_Pred_Taken),
        .ROB_Tag(ROB_Tag), .ROB_Full(ROB_Full),
        .CDB_Tag(CDB_Tag), .CDB_Data(CDB_Data), .CDB_Valid(CDB_Valid),
        .CDB_Branch(CDB_Branch), .CDB_Branch_Taken(CDB_Branch_Taken),
        .Retire_Valid(Retire_Valid), .Retire_Rd_Reg(Retire_Rd_Reg),
        .Retire_Data(Retire_Data), .Retire_Tag(Retire_Tag),
        .RB_Store_Ready(RB_Store_Ready), .RB_Flush_Valid(RB_Flush_Valid)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  tag;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        st;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    typedef struct {
        logic        rst;
        logic        dv;
        logic [4:0]  rd;
        logic        st;
        logic [31:0] pdata;
        logic        cv;
        logic [4:0]  ct;
        logic [31:0] cd;
        logic [4:0]  etag;
        logic        erv;
        logic [4:0]  erd;
        logic [31:0] edata;
        logic [4:0]  ertag;
        logic        est;
    } vec_t;

    vec_t tbl[16];

    function automatic vec_t v(logic rst, logic dv, logic [4:0] rd, logic st, logic [31:0] pdata,
                               logic cv, logic [4:0] ct, logic [31:0] cd, logic [4:0] etag,
                               logic erv, logic [4:0] erd, logic [31:0] edata,
                               logic [4:0] ertag, logic est);
        vec_t r;
        r.rst = rst; r.dv = dv; r.rd = rd; r.st = st; r.pdata = pdata;
        r.cv = cv; r.ct = ct; r.cd = cd; r.etag = etag; r.erv = erv;
        r.erd = erd; r.edata = edata; r.ertag = ertag; r.est = est;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [4:0] tag, input logic [4:0] rd, input logic [31:0] data,
                        input logic st);
        exp_t e;
        e.tag = tag; e.rd = rd; e.data = data; e.st = st;
        sb.push_back(e);
    endtask

    task automatic drive(input logic dv, input logic [4:0] rd, input logic st, input logic br,
                         input logic pt, input logic cv, input logic [4:0] ct,
                         input logic [31:0] cd, input logic cbr, input logic ctk);
        Dispatch_Valid = dv; Dispatch_Rd_Reg = rd; Dispatch_Is_Store = st;
        Dispatch_Is_Branch = br; Dispatch_Pred_Taken = pt;
        CDB_Valid = cv; CDB_Tag = ct; CDB_Data = cd; CDB_Branch = cbr; CDB_Branch_Taken = ctk;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        Rst = 1'b0;
        step();
        step();
        chk("rst_tag", 32'(ROB_Tag), 32'd0);
        chk("rst_full", 32'(ROB_Full), 32'd0);
        chk("rst_rv", 32'(Retire_Valid), 32'd0);
        chk("rst_st", 32'(RB_Store_Ready), 32'd0);
        chk("rst_flush", 32'(RB_Flush_Valid), 32'd0);
        sb.delete();
        Rst = 1'b1;
    endtask

    // Scoreboard monitor: every retire writeback or store-commit pulse must match the queue head.
    always @(posedge Clk) begin
        #1;
        if (Rst && (Retire_Valid || RB_Store_Ready)) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected rv=%b st=%b tag=%0d with empty queue at %0t",
                         Retire_Valid, RB_Store_Ready, Retire_Tag, $time);
            end else begin
                mon_e = sb.pop_front();
                if (Retire_Valid !== !mon_e.st || RB_Store_Ready !== mon_e.st ||
                    Retire_Tag !== mon_e.tag ||
                    (!mon_e.st && (Retire_Rd_Reg !== mon_e.rd || Retire_Data !== mon_e.data))) begin
                    errors++;
                    $display("FAIL sb_retire got rv=%b st=%b tag=%0d rd=%0d data=%h want st=%b tag=%0d rd=%0d data=%h at %0t",
                             Retire_Valid, RB_Store_Ready, Retire_Tag, Retire_Rd_Reg, Retire_Data,
                             mon_e.st, mon_e.tag, mon_e.rd, mon_e.data, $time);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1);
    end

    initial begin
        Rst = 1'b0;
        idle();
        //            rst dv rd st pdata   cv ct cd     etag erv erd edata  ertag est
        tbl[0]  = v(1, 1, 1, 0, 32'hA,  0, 0, 32'h0, 1, 0, 0, 32'h0,  0, 0);
        tbl[1]  = v(0, 1, 2, 0, 32'hB,  0, 0, 32'h0, 2, 0, 0, 32'h0,  0, 0);
        tbl[2]  = v(0, 1, 3, 0, 32'hC,  0, 0, 32'h0, 3, 0, 0, 32'h0,  0, 0);
        tbl[3]  = v(0, 0, 0, 0, 32'h0,  1, 1, 32'hB, 3, 0, 0, 32'h0,  0, 0);
        tbl[4]  = v(0, 0, 0, 0, 32'h0,  1, 0, 32'hA, 3, 0, 0, 32'h0,  0, 0);
        tbl[5]  = v(0, 0, 0, 0, 32'h0,  1, 2, 32'hC, 3, 1, 1, 32'hA,  0, 0);
        tbl[6]  = v(0, 0, 0, 0, 32'h0,  0, 0, 32'h0, 3, 1, 2, 32'hB,  1, 0);
        tbl[7]  = v(0, 0, 0, 0, 32'h0,  0, 0, 32'h0, 3, 1, 3, 32'hC,  2, 0);
        tbl[8]  = v(0, 0, 0, 0, 32'h0,  0, 0, 32'h0, 3, 0, 0, 32'h0,  0, 0);
        tbl[9]  = v(1, 1, 0, 1, 32'h0,  0, 0, 32'h0, 1, 0, 0, 32'h0,  0, 0);
        tbl[10] = v(0, 1, 5, 0, 32'h55, 0, 0, 32'h0, 2, 0, 0, 32'h0,  0, 1);
        tbl[11] = v(0, 0, 0, 0, 32'h0,  0, 0, 32'h0, 2, 0, 0, 32'h0,  0, 0);
        tbl[12] = v(0, 0, 0, 0, 32'h0,  0, 0, 32'h0, 2, 0, 0, 32'h0,  0, 0);
        tbl[13] = v(0, 0, 0, 0, 32'h0,  1, 1, 32'h55, 2, 0, 0, 32'h0, 0, 0);
        tbl[14] = v(0, 0, 0, 0, 32'h0,  0, 0, 32'h0, 2, 1, 5, 32'h55, 1, 0);
        tbl[15] = v(0, 0, 0, 0, 32'h0,  0, 0, 32'h0, 2, 0, 0, 32'h0,  0, 0);

        do_reset();

        // In-order retire and store commit
        for (int i = 0; i < 16; i++) begin
            if (tbl[i].rst) do_reset();
            drive(tbl[i].dv, tbl[i].rd, tbl[i].st, 1'b0, 1'b0,
                  tbl[i].cv, tbl[i].ct, tbl[i].cd, 1'b0, 1'b0);
            if (tbl[i].dv) push(tbl[i].etag - 5'd1, tbl[i].rd, tbl[i].pdata, tbl[i].st);
            step();
            chk($sformatf("v%0d_tag", i), 32'(ROB_Tag), 32'(tbl[i].etag));
            chk($sformatf("v%0d_full", i), 32'(ROB_Full), 32'd0);
            chk($sformatf("v%0d_rv", i), 32'(Retire_Valid), 32'(tbl[i].erv));
            chk($sformatf("v%0d_st", i), 32'(RB_Store_Ready), 32'(tbl[i].est));
            chk($sformatf("v%0d_flush", i), 32'(RB_Flush_Valid), 32'd0);
            if (tbl[i].erv) begin
                chk($sformatf("v%0d_rd", i), 32'(Retire_Rd_Reg), 32'(tbl[i].erd));
                chk($sformatf("v%0d_data", i), Retire_Data, tbl[i].edata);
            end
            if (tbl[i].erv || tbl[i].est)
                chk($sformatf("v%0d_rtag", i), 32'(Retire_Tag), 32'(tbl[i].ertag));
        end
        idle();

        // Full, ignored 33rd dispatch, retire while full, wrap
        do_reset();
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 5'(i + 1), 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
            if (i == 0) push(5'd0, 5'd1, 32'h1234, 1'b0);
            step();
            if (i == 30) chk("full_at31", 32'(ROB_Full), 32'd0);
        end
        chk("full_set", 32'(ROB_Full), 32'd1);
        chk("full_tag", 32'(ROB_Tag), 32'd0);
        drive(1'b1, 5'd31, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        step();
        chk("full_33_tag", 32'(ROB_Tag), 32'd0);
        chk("full_33_full", 32'(ROB_Full), 32'd1);
        drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'h1234, 1'b0, 1'b0);
        step();
        chk("full_cdb_full", 32'(ROB_Full), 32'd1);
        chk("full_cdb_rv", 32'(Retire_Valid), 32'd0);
        drive(1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        step();
        chk("full_ret_rv", 32'(Retire_Valid), 32'd1);
        chk("full_ret_full", 32'(ROB_Full), 32'd0);
        chk("full_ret_tag", 32'(ROB_Tag), 32'd0);
        step();
        chk("wrap_tag", 32'(ROB_Tag), 32'd1);
        chk("wrap_full", 32'(ROB_Full), 32'd1);
        idle();

        // Mispredict flush with a dispatch in the flush cycle
        do_reset();
        drive(1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        step();
        drive(1'b1, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        step();
        drive(1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        step();
        chk("fl_tag3", 32'(ROB_Tag), 32'd3);
        drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 32'h44, 1'b0, 1'b0);
        step();
        chk("fl_norv", 32'(Retire_Valid), 32'd0);
        drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'h0, 1'b1, 1'b1);
        step();
        chk("fl_pre", 32'(RB_Flush_Valid), 32'd0);
        drive(1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        step();
        chk("fl_pulse", 32'(RB_Flush_Valid), 32'd1);
        chk("fl_tag0", 32'(ROB_Tag), 32'd0);
        chk("fl_rv", 32'(Retire_Valid), 32'd0);
        chk("fl_full", 32'(ROB_Full), 32'd0);
        idle();
        step();
        chk("fl_single", 32'(RB_Flush_Valid), 32'd0);
        chk("fl_tag_hold", 32'(ROB_Tag), 32'd0);
        step();
        step();
        drive(1'b1, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        push(5'd0, 5'd6, 32'h66, 1'b0);
        step();
        chk("fl_resume_tag", 32'(ROB_Tag), 32'd1);
        drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'h66, 1'b0, 1'b0);
        step();
        idle();
        step();
        chk("fl_resume_rv", 32'(Retire_Valid), 32'd1);

        // Correctly predicted branch
        do_reset();
        drive(1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        step();
        drive(1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        push(5'd1, 5'd7, 32'h77, 1'b0);
        step();
        drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'h0, 1'b1, 1'b1);
        step();
        drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 32'h77, 1'b0, 1'b0);
        step();
        chk("br_noflush", 32'(RB_Flush_Valid), 32'd0);
        chk("br_norv", 32'(Retire_Valid), 32'd0);
        idle();
        step();
        chk("br_next_rv", 32'(Retire_Valid), 32'd1);
        chk("br_next_data", Retire_Data, 32'h77);
        chk("br_next_rtag", 32'(Retire_Tag), 32'd1);
        chk("br_next_flush", 32'(RB_Flush_Valid), 32'd0);
        chk("br_tag", 32'(ROB_Tag), 32'd2);

        // Ignored CDB writes, then asynchronous reset mid-stream
        do_reset();
        drive(1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        push(5'd0, 5'd8, 32'h88, 1'b0);
        step();
        drive(1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        push(5'd1, 5'd9, 32'h11, 1'b0);
        step();
        drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'hDEAD, 1'b0, 1'b0);
        step();
        chk("ig_tag", 32'(ROB_Tag), 32'd2);
        chk("ig_rv", 32'(Retire_Valid), 32'd0);
        drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 32'h11, 1'b0, 1'b0);
        step();
        drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 32'h22, 1'b0, 1'b0);
        step();
        drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'h88, 1'b0, 1'b0);
        step();
        idle();
        step();
        chk("ig_ret0", Retire_Data, 32'h88);
        step();
        chk("ig_ret1", Retire_Data, 32'h11);
        drive(1'b1, 5'd10, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        push(5'd2, 5'd10, 32'h10, 1'b0);
        step();
        drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd2, 32'h10, 1'b0, 1'b0);
        step();
        idle();
        step();
        chk("ar_pre_rv", 32'(Retire_Valid), 32'd1);
        #2;
        Rst = 1'b0;
        #1;
        chk("ar_rv", 32'(Retire_Valid), 32'd0);
        chk("ar_tag", 32'(ROB_Tag), 32'd0);
        chk("ar_full", 32'(ROB_Full), 32'd0);
        chk("ar_data", Retire_Data, 32'd0);
        chk("ar_rtag", 32'(Retire_Tag), 32'd0);
        @(negedge Clk);
        Rst = 1'b1;
        step();
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
